// File: rtl/gen_pack_pkg.sv
// Shared types and constants for the Avalon-ST Ethernet frame generator.
// Holds the FSM encoding, frame-size constants and the latched configuration struct.
package gen_pack_pkg;

  localparam int unsigned ETH_HDR_BYTES     = 14;
  localparam int unsigned MIN_PAYLOAD_BYTES = 46;
  localparam int unsigned MAX_PAYLOAD_BYTES = 1500;

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StHdr,
    StPay
  } state_e;

  typedef struct packed {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] ethertype;
    logic [10:0] len;
    logic [15:0] cnt;
    logic [7:0]  gap;
  } cfg_t;

  function automatic logic [10:0] clamp_len(input logic [10:0] len,
                                            input logic [10:0] lo,
                                            input logic [10:0] hi);
    if (len < lo) return lo;
    if (len > hi) return hi;
    return len;
  endfunction

endpackage

// File: rtl/gen_pack_payload_word.sv
// Combinational payload packer: four big-endian bytes of the incrementing pattern for the
// beat starting at frame byte offset byte_off_i, plus a mask of which bytes are payload.
module gen_pack_payload_word
  import gen_pack_pkg::*;
(
  input  logic [10:0] byte_off_i,
  input  logic [7:0]  seed_i,
  input  logic [10:0] len_i,
  output logic [31:0] word_o,
  output logic [3:0]  mask_o
);

  logic [11:0] end_pos;

  assign end_pos = 12'(ETH_HDR_BYTES) + {1'b0, len_i};

  for (genvar j = 0; j < 4; j++) begin : g_byte
    logic [11:0] pos;
    assign pos = {1'b0, byte_off_i} + 12'(j);
    assign mask_o[3-j] = (pos >= 12'(ETH_HDR_BYTES)) && (pos < end_pos);
    // Payload byte k sits at frame offset k+14, so value = pos - 14 + seed (mod 256).
    assign word_o[31-8*j -: 8] = pos[7:0] - 8'(ETH_HDR_BYTES) + seed_i;
  end

endmodule

// File: rtl/gen_pack_tx_st.sv
// Avalon-ST frame source: after TSE init and a start pulse, streams N Ethernet frames
// (14-byte header then incrementing payload) into the MAC TX FIFO; MAC appends the CRC.
module gen_pack_tx_st
  import gen_pack_pkg::*;
#(
  parameter int unsigned MIN_PAYLOAD = MIN_PAYLOAD_BYTES,
  parameter int unsigned MAX_PAYLOAD = MAX_PAYLOAD_BYTES,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              tse_init_done_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [47:0]       cfg_dst_mac_i,
  input  logic [47:0]       cfg_src_mac_i,
  input  logic [15:0]       cfg_ethertype_i,
  input  logic [10:0]       cfg_payload_len_i,
  input  logic [15:0]       cfg_pkt_cnt_i,
  input  logic [7:0]        cfg_gap_i,
  input  logic              tx_ready_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_valid_o,
  output logic              tx_sop_o,
  output logic              tx_eop_o,
  output logic [1:0]        tx_empty_o,
  output logic              tx_error_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       sent_cnt_o
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("gen_pack_tx_st: only DATA_W = 32 is supported");
  end

  localparam logic [10:0] MinLen = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MaxLen = 11'(MAX_PAYLOAD);

  state_e      state_q, state_d;
  cfg_t        cfg_q, cfg_d;
  logic [15:0] idx_q, idx_d;
  logic [8:0]  beat_q, beat_d;
  logic [7:0]  gap_q, gap_d;
  logic        stop_pend_q, stop_pend_d;
  logic        done_q, done_d;
  logic [31:0] sent_q, sent_d;

  logic [11:0] frame_bytes;
  logic [8:0]  last_beat;
  logic [1:0]  empty_eop;
  logic        valid, is_last, xfer, stop_now, seq_end;
  logic [15:0] idx_inc;
  logic [31:0] pay_word, pay_data, beat_data;
  logic [3:0]  pay_mask;

  assign frame_bytes = 12'(ETH_HDR_BYTES) + {1'b0, cfg_q.len};
  assign last_beat   = 9'((frame_bytes - 12'd1) >> 2);
  assign empty_eop   = 2'(3'd4 - {1'b0, frame_bytes[1:0]});
  assign valid       = (state_q == StHdr) || (state_q == StPay);
  assign is_last     = (beat_q == last_beat);
  assign xfer        = valid && tx_ready_i;
  // A dropped init-done is handled exactly like a stop request.
  assign stop_now    = stop_pend_q || stop_i || !tse_init_done_i;
  assign idx_inc     = idx_q + 16'd1;
  assign seq_end     = ((cfg_q.cnt != 16'd0) && (idx_inc == cfg_q.cnt)) || stop_now;

  gen_pack_payload_word u_payload_word (
    .byte_off_i ({beat_q, 2'b00}),
    .seed_i     (idx_q[7:0]),
    .len_i      (cfg_q.len),
    .word_o     (pay_word),
    .mask_o     (pay_mask)
  );

  assign pay_data = pay_word & {{8{pay_mask[3]}}, {8{pay_mask[2]}},
                                {8{pay_mask[1]}}, {8{pay_mask[0]}}};

  always_comb begin
    beat_data = pay_data;
    case (beat_q)
      9'd0:    beat_data = cfg_q.dst[47:16];
      9'd1:    beat_data = {cfg_q.dst[15:0], cfg_q.src[47:32]};
      9'd2:    beat_data = cfg_q.src[31:0];
      9'd3:    beat_data = {cfg_q.ethertype, pay_data[15:0]};
      default: beat_data = pay_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cfg_d       = cfg_q;
    idx_d       = idx_q;
    beat_d      = beat_q;
    gap_d       = gap_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    sent_d      = sent_q;

    if ((state_q != StIdle) && (stop_i || !tse_init_done_i)) stop_pend_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        // Stop in idle (including one coincident with start) is discarded.
        stop_pend_d = 1'b0;
        if (start_i && tse_init_done_i) begin
          cfg_d = '{dst:       cfg_dst_mac_i,
                    src:       cfg_src_mac_i,
                    ethertype: cfg_ethertype_i,
                    len:       clamp_len(cfg_payload_len_i, MinLen, MaxLen),
                    cnt:       cfg_pkt_cnt_i,
                    gap:       cfg_gap_i};
          idx_d   = '0;
          beat_d  = '0;
          gap_d   = cfg_gap_i;
          state_d = (cfg_gap_i == 8'd0) ? StHdr : StGap;
        end
      end
      StGap: begin
        if (stop_now) begin
          state_d     = StIdle;
          stop_pend_d = 1'b0;
          done_d      = 1'b1;
        end else if (gap_q <= 8'd1) begin
          state_d = StHdr;
          beat_d  = '0;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      StHdr, StPay: begin
        if (xfer) begin
          if (state_q == StPay && is_last) begin
            sent_d = sent_q + 32'd1;
            idx_d  = idx_inc;
            beat_d = '0;
            if (seq_end) begin
              state_d     = StIdle;
              stop_pend_d = 1'b0;
              done_d      = 1'b1;
            end else begin
              gap_d   = cfg_q.gap;
              state_d = (cfg_q.gap == 8'd0) ? StHdr : StGap;
            end
          end else begin
            beat_d = beat_q + 9'd1;
            if (beat_q == 9'd3) state_d = StPay;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= StIdle;
      cfg_q       <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      gap_q       <= '0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      sent_q      <= '0;
    end else begin
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      idx_q       <= idx_d;
      beat_q      <= beat_d;
      gap_q       <= gap_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      sent_q      <= sent_d;
    end
  end

  assign tx_valid_o = valid;
  assign tx_data_o  = valid ? beat_data : '0;
  assign tx_sop_o   = valid && (beat_q == 9'd0);
  assign tx_eop_o   = (state_q == StPay) && is_last;
  assign tx_empty_o = tx_eop_o ? empty_eop : 2'd0;
  assign tx_error_o = 1'b0;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign sent_cnt_o = sent_q;

endmodule
